prog_loader: RTL

//   Host-side program writer for the 4-bit CPU: accepts instruction bytes from an external

---
 rtl/prog_loader.sv | 139 +++++++++++++
 1 files changed

// File: rtl/prog_loader.sv
// Host-side program loader for the 4-bit CPU.
// Takes instruction bytes from a host over a four-phase valid/ack handshake and writes them
// sequentially into the instruction memory. Holds the CPU off (cpu_run_o = 0) while loading.
module prog_loader #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena_i,
  input  logic              load_mode_i,
  input  logic              host_valid_i,
  input  logic [DATA_W-1:0] host_data_i,
  output logic              host_ack_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic              cpu_run_o,
  output logic [ADDR_W:0]   word_count_o,
  output logic              overflow_o
);

  localparam logic [ADDR_W:0] Depth = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StWrite,
    StAck,
    StRun
  } state_e;

  state_e            state_q, state_d;
  logic              armed_q;
  logic              load_q1, load_s;
  logic              valid_q1, valid_s;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              ovf_q, ovf_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;

  // Two-flop synchronisers for the asynchronous host strobes; frozen while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q1  <= 1'b0;
      load_s   <= 1'b0;
      valid_q1 <= 1'b0;
      valid_s  <= 1'b0;
    end else if (ena_i) begin
      load_q1  <= load_mode_i;
      load_s   <= load_q1;
      valid_q1 <= host_valid_i;
      valid_s  <= valid_q1;
    end
  end

  // State and datapath registers; armed_q delays the first IDLE decision by one edge after
  // reset release so the FSM leaves IDLE on a clean, synchronously deasserted cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      armed_q <= 1'b0;
      addr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      wdata_q <= '0;
    end else if (ena_i) begin
      state_q <= state_d;
      armed_q <= 1'b1;
      addr_q  <= addr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      wdata_q <= wdata_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (armed_q) state_d = load_s ? StLoad : StRun;
      end
      StLoad: begin
        // A pending transfer takes priority over leaving load mode.
        if (valid_s)      state_d = StWrite;
        else if (!load_s) state_d = StRun;
      end
      StWrite: state_d = StAck;
      StAck: begin
        if (!valid_s) state_d = StLoad;
      end
      StRun: begin
        if (load_s) state_d = StLoad;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: address, word counter, sticky overflow and captured data.
  always_comb begin
    addr_d  = addr_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    wdata_d = wdata_q;
    unique case (state_q)
      StIdle, StRun: begin
        if (state_d == StLoad) begin
          addr_d  = '0;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      StLoad: begin
        if (valid_s) wdata_d = host_data_i;
      end
      StWrite: begin
        if (count_q == Depth) ovf_d = 1'b1;
        else                  count_d = count_q + 1'b1;
      end
      StAck: begin
        if (!valid_s) addr_d = addr_q + 1'b1;
      end
      default: ;
    endcase
  end

  // Outputs decoded from registered state; the write strobe is suppressed while disabled.
  always_comb begin
    mem_we_o     = ena_i && (state_q == StWrite);
    host_ack_o   = (state_q == StAck);
    cpu_run_o    = (state_q == StRun);
    mem_addr_o   = addr_q;
    mem_wdata_o  = wdata_q;
    word_count_o = count_q;
    overflow_o   = ovf_q;
  end

endmodule
